// File: rtl/input_pack_ctrl.sv
// ---------------------------------------------------------------------------
// input_pack_ctrl
//   Front-end packer for the PolyEval datapath. It collects LANES consecutive
//   WID_D-bit coefficient words into one group, and keeps the groups in a
//   BANKS-deep ring of register banks so that input and output can proceed
//   in the same cycle. Full groups go to the evaluator with valid/ready
//   backpressure. Lane 0 holds the oldest word of a group.
//
//   Optional feature: define INPUT_PACK_FLUSH_EN to add flush_i/last_o. A
//   flush closes a partial group early. Unwritten lanes of that group read
//   as 0, and the group is tagged with last_o.
//
// Handshake: a transfer takes place on a rising clk edge where valid and
//   ready are both 1. Valid never waits for ready. dt_rdy_o is derived only
//   from registered state, so there is no combinational path from dt_rdy_i.
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous reset, active-high
//   data_i    input word
//   dt_vld_i  input word valid
//   dt_rdy_o  input ready (write bank has room)
//   a_o       output group, lane k at a_o[k*WID_D +: WID_D], 0 when idle
//   dt_vld_o  output group valid
//   dt_rdy_i  downstream ready
//   flush_i   close partial group   (INPUT_PACK_FLUSH_EN only)
//   last_o    group closed by flush (INPUT_PACK_FLUSH_EN only)
//   occ_o     number of full banks, 0..BANKS
// ---------------------------------------------------------------------------
module input_pack_ctrl #(
    parameter int WID_D = 32,
    parameter int LANES = 2,
    parameter int BANKS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WID_D-1:0]           data_i,
    input  logic                       dt_vld_i,
    output logic                       dt_rdy_o,
    output logic [LANES*WID_D-1:0]     a_o,
    output logic                       dt_vld_o,
    input  logic                       dt_rdy_i,
`ifdef INPUT_PACK_FLUSH_EN
    input  logic                       flush_i,
    output logic                       last_o,
`endif
    output logic [$clog2(BANKS+1)-1:0] occ_o
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BW = $clog2(BANKS);
    localparam int OW = $clog2(BANKS+1);

    logic [WID_D-1:0] bank_q [BANKS][LANES];
    logic [BANKS-1:0] bank_full_q;
    logic [BW-1:0]    wr_bank_q;
    logic [BW-1:0]    rd_bank_q;
    logic [LW-1:0]    wr_lane_q;
    logic [OW-1:0]    occ_q;

    logic accept;
    logic consume;
    logic close;
    logic [BW-1:0] wr_bank_nxt;
    logic [BW-1:0] rd_bank_nxt;

    assign dt_rdy_o = !bank_full_q[wr_bank_q];
    assign dt_vld_o = bank_full_q[rd_bank_q];
    assign occ_o    = occ_q;

    assign accept  = dt_vld_i && dt_rdy_o;
    assign consume = dt_vld_o && dt_rdy_i;

    assign wr_bank_nxt = (wr_bank_q == BW'(BANKS-1)) ? '0 : wr_bank_q + 1'b1;
    assign rd_bank_nxt = (rd_bank_q == BW'(BANKS-1)) ? '0 : rd_bank_q + 1'b1;

`ifdef INPUT_PACK_FLUSH_EN
    logic [LANES-1:0] wr_mask_q;  // lanes of the open bank written so far
    logic [BANKS-1:0] last_q;
    logic             flush_close;

    // A flush closes the open group only if it holds at least one word,
    // which includes a word accepted on this same edge.
    assign flush_close = flush_i && dt_rdy_o && ((wr_lane_q != '0) || accept);
    assign close       = (accept && (wr_lane_q == LW'(LANES-1))) || flush_close;
    assign last_o      = last_q[rd_bank_q] && dt_vld_o;
`else
    assign close = accept && (wr_lane_q == LW'(LANES-1));
`endif

    // Output group is forced to zero whenever no group is presented.
    always_comb begin
        a_o = '0;
        if (dt_vld_o) begin
            for (int l = 0; l < LANES; l++) begin
                a_o[l*WID_D +: WID_D] = bank_q[rd_bank_q][l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full_q <= '0;
            wr_bank_q   <= '0;
            rd_bank_q   <= '0;
            wr_lane_q   <= '0;
            occ_q       <= '0;
`ifdef INPUT_PACK_FLUSH_EN
            wr_mask_q   <= '0;
            last_q      <= '0;
`endif
        end else begin
            if (accept) begin
                bank_q[wr_bank_q][wr_lane_q] <= data_i;
            end
`ifdef INPUT_PACK_FLUSH_EN
            // Zero every lane that was never written, so stale data from an
            // earlier group cannot leak out of a short group.
            if (flush_close) begin
                for (int l = 0; l < LANES; l++) begin
                    if (!wr_mask_q[l] && !(accept && (wr_lane_q == LW'(l)))) begin
                        bank_q[wr_bank_q][l] <= '0;
                    end
                end
            end
`endif
            if (close) begin
                bank_full_q[wr_bank_q] <= 1'b1;
                wr_lane_q              <= '0;
                wr_bank_q              <= wr_bank_nxt;
`ifdef INPUT_PACK_FLUSH_EN
                wr_mask_q              <= '0;
                last_q[wr_bank_q]      <= flush_i;
`endif
            end else if (accept) begin
                wr_lane_q              <= wr_lane_q + 1'b1;
`ifdef INPUT_PACK_FLUSH_EN
                wr_mask_q[wr_lane_q]   <= 1'b1;
`endif
            end
            // Filling requires the write bank to be empty, and consuming
            // requires the read bank to be full. The two indices therefore
            // differ whenever both happen in the same cycle.
            if (consume) begin
                bank_full_q[rd_bank_q] <= 1'b0;
                rd_bank_q              <= rd_bank_nxt;
            end
            occ_q <= occ_q + OW'(close) - OW'(consume);
        end
    end

endmodule

// File: tb/tb_input_pack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_input_pack_ctrl
//   Directed bench for input_pack_ctrl (WID_D=32, LANES=2, BANKS=2).
//   Inputs change 1 ns after a rising edge, and outputs are checked at that
//   same point, which is away from the active edge.
// ---------------------------------------------------------------------------
module tb_input_pack_ctrl;

    localparam int WID_D = 32;
    localparam int LANES = 2;
    localparam int BANKS = 2;
    localparam int OW    = $clog2(BANKS+1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [WID_D-1:0]       data_i;
    logic                   dt_vld_i;
    logic                   dt_rdy_o;
    logic [LANES*WID_D-1:0] a_o;
    logic                   dt_vld_o;
    logic                   dt_rdy_i;
    logic [OW-1:0]          occ_o;
`ifdef INPUT_PACK_FLUSH_EN
    logic                   flush_i;
    logic                   last_o;
`endif

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    input_pack_ctrl #(.WID_D(WID_D), .LANES(LANES), .BANKS(BANKS)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_i   (data_i),
        .dt_vld_i (dt_vld_i),
        .dt_rdy_o (dt_rdy_o),
        .a_o      (a_o),
        .dt_vld_o (dt_vld_o),
        .dt_rdy_i (dt_rdy_i),
`ifdef INPUT_PACK_FLUSH_EN
        .flush_i  (flush_i),
        .last_o   (last_o),
`endif
        .occ_o    (occ_o)
    );

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every observable output: ready, valid, occupancy and group.
    task automatic chk_all(input string tag, input logic rdy, input logic vld,
                           input logic [OW-1:0] occ, input logic [63:0] grp);
        chk({tag, ".rdy"}, 64'(dt_rdy_o), 64'(rdy));
        chk({tag, ".vld"}, 64'(dt_vld_o), 64'(vld));
        chk({tag, ".occ"}, 64'(occ_o), 64'(occ));
        chk({tag, ".a"},   64'(a_o), grp);
    endtask

    function automatic logic [63:0] grp2(input logic [31:0] l0, input logic [31:0] l1);
        return {l1, l0};
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b1;
        data_i   = '0;
        dt_vld_i = 1'b0;
        dt_rdy_i = 1'b0;
`ifdef INPUT_PACK_FLUSH_EN
        flush_i  = 1'b0;
`endif

        // 1: reset held for two edges
        step();
        step();
        rst = 1'b0;
        chk_all("reset", 1'b1, 1'b0, 2'd0, 64'h0);

        // 2: back-to-back stream with downstream always ready
        dt_rdy_i = 1'b1;
        dt_vld_i = 1'b1;
        data_i = 32'h11; step(); chk_all("s2.w1", 1'b1, 1'b0, 2'd0, 64'h0);
        data_i = 32'h22; step(); chk_all("s2.w2", 1'b1, 1'b1, 2'd1, grp2(32'h11, 32'h22));
        data_i = 32'h33; step(); chk_all("s2.w3", 1'b1, 1'b0, 2'd0, 64'h0);
        data_i = 32'h44; step(); chk_all("s2.w4", 1'b1, 1'b1, 2'd1, grp2(32'h33, 32'h44));
        dt_vld_i = 1'b0; step(); chk_all("s2.drain", 1'b1, 1'b0, 2'd0, 64'h0);

        // 3: backpressure fills the ring, then drain in order
        dt_rdy_i = 1'b0;
        dt_vld_i = 1'b1;
        data_i = 32'h101; step();
        data_i = 32'h102; step(); chk_all("s3.g0", 1'b1, 1'b1, 2'd1, grp2(32'h101, 32'h102));
        data_i = 32'h103; step();
        data_i = 32'h104; step(); chk_all("s3.full", 1'b0, 1'b1, 2'd2, grp2(32'h101, 32'h102));
        data_i = 32'h105; step(); chk_all("s3.hold1", 1'b0, 1'b1, 2'd2, grp2(32'h101, 32'h102));
        step();                   chk_all("s3.hold2", 1'b0, 1'b1, 2'd2, grp2(32'h101, 32'h102));
        dt_rdy_i = 1'b1;
        step(); chk_all("s3.d0", 1'b1, 1'b1, 2'd1, grp2(32'h103, 32'h104));
        step(); chk_all("s3.d1", 1'b1, 1'b0, 2'd0, 64'h0);
        data_i = 32'h106; step(); chk_all("s3.g2", 1'b1, 1'b1, 2'd1, grp2(32'h105, 32'h106));
        dt_vld_i = 1'b0; step(); chk_all("s3.drain", 1'b1, 1'b0, 2'd0, 64'h0);

        // 4: ten groups, each consume of group g-1 coincides with the final
        //    lane of group g, so occupancy stays at 1 across the wraps
        dt_vld_i = 1'b1;
        for (int g = 0; g < 10; g++) begin
            logic [31:0] w0;
            logic [31:0] w1;
            w0 = 32'h300 + 32'(2*g);
            w1 = w0 + 32'd1;
            dt_rdy_i = 1'b0;
            data_i = w0; step();
            if (g > 0) chk_all("s4.lane0", 1'b1, 1'b1, 2'd1, grp2(w0 - 32'd2, w0 - 32'd1));
            dt_rdy_i = (g > 0);
            data_i = w1; step();
            chk_all("s4.lane1", 1'b1, 1'b1, 2'd1, grp2(w0, w1));
        end
        dt_vld_i = 1'b0;
        dt_rdy_i = 1'b1;
        step(); chk_all("s4.drain", 1'b1, 1'b0, 2'd0, 64'h0);

        // 5: reset discards one full group and one partial group
        dt_rdy_i = 1'b0;
        dt_vld_i = 1'b1;
        data_i = 32'h501; step();
        data_i = 32'h502; step();
        data_i = 32'h503; step(); chk_all("s5.pre", 1'b1, 1'b1, 2'd1, grp2(32'h501, 32'h502));
        dt_vld_i = 1'b0;
        rst = 1'b1; step();
        rst = 1'b0;
        chk_all("s5.rst", 1'b1, 1'b0, 2'd0, 64'h0);
        dt_rdy_i = 1'b1;
        dt_vld_i = 1'b1;
        data_i = 32'h511; step(); chk_all("s5.w1", 1'b1, 1'b0, 2'd0, 64'h0);
        data_i = 32'h512; step(); chk_all("s5.w2", 1'b1, 1'b1, 2'd1, grp2(32'h511, 32'h512));
        dt_vld_i = 1'b0; step(); chk_all("s5.drain", 1'b1, 1'b0, 2'd0, 64'h0);

`ifdef INPUT_PACK_FLUSH_EN
        // 6: flush of a one-word group, then a flush with nothing pending.
        //    The bank being flushed still holds stale data in lane 1.
        dt_rdy_i = 1'b0;
        dt_vld_i = 1'b1;
        data_i = 32'hA; step();
        chk("s6.last_pre", 64'(last_o), 64'h0);
        dt_vld_i = 1'b0;
        flush_i = 1'b1; step();
        flush_i = 1'b0;
        chk_all("s6.flush", 1'b1, 1'b1, 2'd1, grp2(32'hA, 32'h0));
        chk("s6.last", 64'(last_o), 64'h1);
        dt_rdy_i = 1'b1; step();
        chk("s6.last_clr", 64'(last_o), 64'h0);
        flush_i = 1'b1; step();
        flush_i = 1'b0;
        chk_all("s6.noop", 1'b1, 1'b0, 2'd0, 64'h0);
`endif

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
